gx_xcvr_rst_seq: RTL



---
 rtl/gx_xcvr_rst_pkg.sv | 25 ++
 rtl/gx_xcvr_rst_rx_lane.sv | 96 +++++++++
 rtl/gx_xcvr_rst_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/gx_xcvr_rst_pkg.sv
// Shared types and helpers for the transceiver reset sequencer.
package gx_xcvr_rst_pkg;

  typedef enum logic [1:0] {
    TX_ANA       = 2'd0,
    TX_WAIT_LOCK = 2'd1,
    TX_READY     = 2'd2
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_ANA      = 2'd0,
    RX_WAIT_LTD = 2'd1,
    RX_READY    = 2'd2
  } rx_state_e;

  // One counter width fits every threshold so TX and RX counters share it.
  function automatic int cnt_width(input int ana_cyc, input int tx_cyc, input int rx_cyc);
    int m;
    m = ana_cyc;
    if (tx_cyc > m) m = tx_cyc;
    if (rx_cyc > m) m = rx_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/gx_xcvr_rst_rx_lane.sv
// One RX lane reset FSM: analog hold, CDR lock qualification, ready.
// In grouped mode the top gates the READY entry (group_ok_i) and forces
// a common re-reset (force_wait_i) when any lane drops out of READY.
module gx_xcvr_rst_rx_lane
  import gx_xcvr_rst_pkg::*;
#(
  parameter int ANA_RST_CYC = 4,
  parameter int RX_LOCK_CYC = 200,
  parameter int CW          = 8
) (
  input  logic clk_50m,
  input  logic rst,
  input  logic rx_cal_busy_s_i,
  input  logic rx_ltd_s_i,
  input  logic group_ok_i,
  input  logic force_wait_i,
  output logic ready_req_o,
  output logic leave_o,
  output logic rx_analogreset_o,
  output logic rx_digitalreset_o,
  output logic rx_ready_o
);

  localparam logic [CW-1:0] ANA_LAST  = CW'(ANA_RST_CYC - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(RX_LOCK_CYC - 1);
  localparam logic [CW-1:0] CNT_SAT   = '1;

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ana_q, ana_d;
  logic          dig_q, dig_d;
  logic          rdy_q, rdy_d;

  // Lane would enter READY on this edge if the group allows it.
  assign ready_req_o = (state_q == RX_WAIT_LTD) && rx_ltd_s_i && (cnt_q >= LOCK_LAST);
  // Lane is about to drop out of READY.
  assign leave_o     = (state_q == RX_READY) && (rx_cal_busy_s_i || !rx_ltd_s_i);

  // Next state, counter and Moore output decode of the next state.
  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
    unique case (state_q)
      RX_ANA: begin
        if ((cnt_q >= ANA_LAST) && !rx_cal_busy_s_i) begin
          state_d = RX_WAIT_LTD;
          cnt_d   = '0;
        end
      end
      RX_WAIT_LTD: begin
        if (!rx_ltd_s_i) begin
          cnt_d = '0;
        end else if ((cnt_q >= LOCK_LAST) && group_ok_i) begin
          state_d = RX_READY;
          cnt_d   = '0;
        end
      end
      RX_READY: begin
        cnt_d = '0;
        if (rx_cal_busy_s_i)                   state_d = RX_ANA;
        else if (!rx_ltd_s_i || force_wait_i)  state_d = RX_WAIT_LTD;
      end
      default: begin
        state_d = RX_ANA;
        cnt_d   = '0;
      end
    endcase
    ana_d = (state_d == RX_ANA);
    dig_d = (state_d != RX_READY);
    rdy_d = (state_d == RX_READY);
  end

  // State, counter and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q <= RX_ANA;
      cnt_q   <= '0;
      ana_q   <= 1'b1;
      dig_q   <= 1'b1;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ana_q   <= ana_d;
      dig_q   <= dig_d;
      rdy_q   <= rdy_d;
    end
  end

  assign rx_analogreset_o  = ana_q;
  assign rx_digitalreset_o = dig_q;
  assign rx_ready_o        = rdy_q;

endmodule

// File: rtl/gx_xcvr_rst_seq.sv
// Multi-lane transceiver reset sequencer: input synchronizers, one shared
// TX FSM and CH_N RX lane FSMs (independent or grouped).
module gx_xcvr_rst_seq
  import gx_xcvr_rst_pkg::*;
#(
  parameter int CH_N        = 4,
  parameter int ANA_RST_CYC = 4,
  parameter int TX_LOCK_CYC = 16,
  parameter int RX_LOCK_CYC = 200,
  parameter int RX_GROUP    = 0
) (
  input  logic            clk_50m,
  input  logic            rst,
  input  logic            pll_locked_i,
  input  logic            pll_cal_busy_i,
  input  logic [CH_N-1:0] tx_cal_busy_i,
  input  logic [CH_N-1:0] rx_cal_busy_i,
  input  logic [CH_N-1:0] rx_is_lockedtodata_i,
  output logic [CH_N-1:0] tx_analogreset_o,
  output logic [CH_N-1:0] tx_digitalreset_o,
  output logic [CH_N-1:0] rx_analogreset_o,
  output logic [CH_N-1:0] rx_digitalreset_o,
  output logic            tx_ready_o,
  output logic [CH_N-1:0] rx_ready_o
);

  localparam int CW     = cnt_width(ANA_RST_CYC, TX_LOCK_CYC, RX_LOCK_CYC);
  localparam int LOCK_W = CH_N + 1;
  localparam int BUSY_W = 2 * CH_N + 1;

  localparam logic [CW-1:0] ANA_LAST  = CW'(ANA_RST_CYC - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(TX_LOCK_CYC - 1);
  localparam logic [CW-1:0] CNT_SAT   = '1;

  logic [LOCK_W-1:0] lock_meta_q, lock_sync_q;
  logic [BUSY_W-1:0] busy_meta_q, busy_sync_q;

  logic              pll_locked_s;
  logic              pll_cal_busy_s;
  logic [CH_N-1:0]   tx_cal_busy_s;
  logic [CH_N-1:0]   rx_cal_busy_s;
  logic [CH_N-1:0]   rx_ltd_s;
  logic              tx_busy_s;

  // Two-flop synchronizers; locks reset deasserted, busies reset asserted.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      lock_meta_q <= '0;
      lock_sync_q <= '0;
      busy_meta_q <= '1;
      busy_sync_q <= '1;
    end else begin
      lock_meta_q <= {rx_is_lockedtodata_i, pll_locked_i};
      lock_sync_q <= lock_meta_q;
      busy_meta_q <= {rx_cal_busy_i, tx_cal_busy_i, pll_cal_busy_i};
      busy_sync_q <= busy_meta_q;
    end
  end

  assign pll_locked_s   = lock_sync_q[0];
  assign rx_ltd_s       = lock_sync_q[LOCK_W-1:1];
  assign pll_cal_busy_s = busy_sync_q[0];
  assign tx_cal_busy_s  = busy_sync_q[CH_N:1];
  assign rx_cal_busy_s  = busy_sync_q[BUSY_W-1:CH_N+1];
  assign tx_busy_s      = pll_cal_busy_s | (|tx_cal_busy_s);

  // ---------------------------------------------------------------- TX FSM
  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic          tx_ana_q, tx_ana_d;
  logic          tx_dig_q, tx_dig_d;
  logic          tx_rdy_q, tx_rdy_d;

  // TX next state; busy takes priority over PLL lock loss in READY.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = (tx_cnt_q == CNT_SAT) ? tx_cnt_q : tx_cnt_q + CW'(1);
    unique case (tx_state_q)
      TX_ANA: begin
        if ((tx_cnt_q >= ANA_LAST) && !tx_busy_s) begin
          tx_state_d = TX_WAIT_LOCK;
          tx_cnt_d   = '0;
        end
      end
      TX_WAIT_LOCK: begin
        if (!pll_locked_s) begin
          tx_cnt_d = '0;
        end else if (tx_cnt_q >= LOCK_LAST) begin
          tx_state_d = TX_READY;
          tx_cnt_d   = '0;
        end
      end
      TX_READY: begin
        tx_cnt_d = '0;
        if (tx_busy_s)          tx_state_d = TX_ANA;
        else if (!pll_locked_s) tx_state_d = TX_WAIT_LOCK;
      end
      default: begin
        tx_state_d = TX_ANA;
        tx_cnt_d   = '0;
      end
    endcase
    tx_ana_d = (tx_state_d == TX_ANA);
    tx_dig_d = (tx_state_d != TX_READY);
    tx_rdy_d = (tx_state_d == TX_READY);
  end

  // TX state, counter and registered outputs.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      tx_state_q <= TX_ANA;
      tx_cnt_q   <= '0;
      tx_ana_q   <= 1'b1;
      tx_dig_q   <= 1'b1;
      tx_rdy_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_ana_q   <= tx_ana_d;
      tx_dig_q   <= tx_dig_d;
      tx_rdy_q   <= tx_rdy_d;
    end
  end

  assign tx_analogreset_o  = {CH_N{tx_ana_q}};
  assign tx_digitalreset_o = {CH_N{tx_dig_q}};
  assign tx_ready_o        = tx_rdy_q;

  // --------------------------------------------------------------- RX lanes
  logic [CH_N-1:0] ready_req;
  logic [CH_N-1:0] leave;
  logic            group_ok;
  logic            force_wait;

  // Grouped mode: release together once every lane is qualified, and
  // re-reset every lane when any one drops out of READY.
  assign group_ok   = (RX_GROUP != 0) ? (&ready_req) : 1'b1;
  assign force_wait = (RX_GROUP != 0) && (|leave);

  for (genvar i = 0; i < CH_N; i++) begin : g_lane
    gx_xcvr_rst_rx_lane #(
      .ANA_RST_CYC (ANA_RST_CYC),
      .RX_LOCK_CYC (RX_LOCK_CYC),
      .CW          (CW)
    ) u_lane (
      .clk_50m           (clk_50m),
      .rst               (rst),
      .rx_cal_busy_s_i   (rx_cal_busy_s[i]),
      .rx_ltd_s_i        (rx_ltd_s[i]),
      .group_ok_i        (group_ok),
      .force_wait_i      (force_wait),
      .ready_req_o       (ready_req[i]),
      .leave_o           (leave[i]),
      .rx_analogreset_o  (rx_analogreset_o[i]),
      .rx_digitalreset_o (rx_digitalreset_o[i]),
      .rx_ready_o        (rx_ready_o[i])
    );
  end

endmodule
